// File: rtl/mseq_pkg.sv
// Shared types and constants for the microcode sequencer: uop word layout,
// next-uPC selectors, FSM states, datapath control encodings and ROM entry points.
package mseq_pkg;

  localparam int unsigned UPC_W  = 5;
  localparam int unsigned CTRL_W = 16;

  localparam logic [UPC_W-1:0] FETCH_ADDR = 5'd18;

  // Instruction entry points in the uop ROM
  localparam logic [UPC_W-1:0] ADDR_LW    = 5'd0;
  localparam logic [UPC_W-1:0] ADDR_SW    = 5'd2;
  localparam logic [UPC_W-1:0] ADDR_ADD   = 5'd4;
  localparam logic [UPC_W-1:0] ADDR_AND   = 5'd5;
  localparam logic [UPC_W-1:0] ADDR_XOR   = 5'd6;
  localparam logic [UPC_W-1:0] ADDR_OR    = 5'd7;
  localparam logic [UPC_W-1:0] ADDR_ADDI  = 5'd8;
  localparam logic [UPC_W-1:0] ADDR_ANDI  = 5'd9;
  localparam logic [UPC_W-1:0] ADDR_XORI  = 5'd10;
  localparam logic [UPC_W-1:0] ADDR_ORI   = 5'd11;
  localparam logic [UPC_W-1:0] ADDR_LUI   = 5'd12;
  localparam logic [UPC_W-1:0] ADDR_AUIPC = 5'd13;
  localparam logic [UPC_W-1:0] ADDR_JAL   = 5'd14;
  localparam logic [UPC_W-1:0] ADDR_JALR  = 5'd16;

  // ctrl bits: [3:0] alu_op, [4] imm_src, [5] reg_we, [6] mem_we, [7] wb_mem,
  // [8] pc_we, [9] link, [10] addr_calc, [11] mem_re
  localparam logic [CTRL_W-1:0] CTRL_LW_ADDR = 16'h0C10;
  localparam logic [CTRL_W-1:0] CTRL_LW_WB   = 16'h00A0;
  localparam logic [CTRL_W-1:0] CTRL_SW_ADDR = 16'h0410;
  localparam logic [CTRL_W-1:0] CTRL_SW_MEM  = 16'h0040;
  localparam logic [CTRL_W-1:0] CTRL_ADD     = 16'h0020;
  localparam logic [CTRL_W-1:0] CTRL_AND     = 16'h0021;
  localparam logic [CTRL_W-1:0] CTRL_XOR     = 16'h0022;
  localparam logic [CTRL_W-1:0] CTRL_OR      = 16'h0023;
  localparam logic [CTRL_W-1:0] CTRL_ADDI    = 16'h0030;
  localparam logic [CTRL_W-1:0] CTRL_ANDI    = 16'h0031;
  localparam logic [CTRL_W-1:0] CTRL_XORI    = 16'h0032;
  localparam logic [CTRL_W-1:0] CTRL_ORI     = 16'h0033;
  localparam logic [CTRL_W-1:0] CTRL_LUI     = 16'h0034;
  localparam logic [CTRL_W-1:0] CTRL_AUIPC   = 16'h0035;
  localparam logic [CTRL_W-1:0] CTRL_TGT     = 16'h0010;
  localparam logic [CTRL_W-1:0] CTRL_JUMP    = 16'h0320;

  typedef enum logic [1:0] {
    NsSeq,
    NsJump,
    NsDispatch,
    NsFetch
  } next_sel_e;

  typedef enum logic [1:0] {
    StFetch,
    StExec,
    StMemWait,
    StHalt
  } state_e;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic              mem_op;
    logic              br_eval;
    next_sel_e         next_sel;
    logic [UPC_W-1:0]  next_addr;
  } uop_t;

  function automatic uop_t mk_uop(logic [CTRL_W-1:0] ctrl, logic mem_op, logic br_eval,
                                  next_sel_e next_sel, logic [UPC_W-1:0] next_addr);
    uop_t u;
    u.ctrl      = ctrl;
    u.mem_op    = mem_op;
    u.br_eval   = br_eval;
    u.next_sel  = next_sel;
    u.next_addr = next_addr;
    return u;
  endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// Decode/datapath/memory-facing signal bundle of the microcode sequencer.
// MSEQ_PERF_EN adds the performance counter outputs.
interface micro_sequencer_if;
  import mseq_pkg::*;

  logic              id_valid_inst;
  logic              id_illegal;
  logic [UPC_W-1:0]  id_decode_addr;
  logic              cond_branch;
  logic              uncond_branch;
  logic              br_cond_true;
  logic              mem_ack;
  logic              id_ready;
  logic [UPC_W-1:0]  upc;
  logic [CTRL_W-1:0] uop_ctrl;
  logic              mem_req;
  logic              take_branch;
  logic              inst_retired;
  logic              halted;
`ifdef MSEQ_PERF_EN
  logic [31:0]       perf_cycles;
  logic [31:0]       perf_retired;
`endif

  modport master (
    output id_valid_inst, id_illegal, id_decode_addr, cond_branch, uncond_branch,
           br_cond_true, mem_ack,
    input  id_ready, upc, uop_ctrl, mem_req, take_branch, inst_retired, halted
`ifdef MSEQ_PERF_EN
    , input perf_cycles, perf_retired
`endif
  );

  modport slave (
    input  id_valid_inst, id_illegal, id_decode_addr, cond_branch, uncond_branch,
           br_cond_true, mem_ack,
    output id_ready, upc, uop_ctrl, mem_req, take_branch, inst_retired, halted
`ifdef MSEQ_PERF_EN
    , output perf_cycles, perf_retired
`endif
  );

endinterface

// File: rtl/uop_rom.sv
// Combinational microcode ROM: maps the current uPC to its uop word.
// Unpopulated addresses return a no-op that goes back to fetch.
module uop_rom
  import mseq_pkg::*;
(
  input  logic [UPC_W-1:0] upc,
  output uop_t             uop
);

  always_comb begin
    uop = mk_uop('0, 1'b0, 1'b0, NsFetch, '0);
    case (upc)
      5'd0:  uop = mk_uop(CTRL_LW_ADDR, 1'b1, 1'b0, NsSeq,      '0);
      5'd1:  uop = mk_uop(CTRL_LW_WB,   1'b0, 1'b0, NsFetch,    '0);
      5'd2:  uop = mk_uop(CTRL_SW_ADDR, 1'b0, 1'b0, NsSeq,      '0);
      5'd3:  uop = mk_uop(CTRL_SW_MEM,  1'b1, 1'b0, NsFetch,    '0);
      5'd4:  uop = mk_uop(CTRL_ADD,     1'b0, 1'b0, NsFetch,    '0);
      5'd5:  uop = mk_uop(CTRL_AND,     1'b0, 1'b0, NsFetch,    '0);
      5'd6:  uop = mk_uop(CTRL_XOR,     1'b0, 1'b0, NsFetch,    '0);
      5'd7:  uop = mk_uop(CTRL_OR,      1'b0, 1'b0, NsFetch,    '0);
      5'd8:  uop = mk_uop(CTRL_ADDI,    1'b0, 1'b0, NsFetch,    '0);
      5'd9:  uop = mk_uop(CTRL_ANDI,    1'b0, 1'b0, NsFetch,    '0);
      5'd10: uop = mk_uop(CTRL_XORI,    1'b0, 1'b0, NsFetch,    '0);
      5'd11: uop = mk_uop(CTRL_ORI,     1'b0, 1'b0, NsFetch,    '0);
      5'd12: uop = mk_uop(CTRL_LUI,     1'b0, 1'b0, NsFetch,    '0);
      5'd13: uop = mk_uop(CTRL_AUIPC,   1'b0, 1'b0, NsFetch,    '0);
      5'd14: uop = mk_uop(CTRL_JUMP,    1'b0, 1'b1, NsFetch,    '0);
      // jalr: compute target, then jump through the shared redirect uop
      5'd16: uop = mk_uop(CTRL_TGT,     1'b0, 1'b0, NsJump,     5'd17);
      5'd17: uop = mk_uop(CTRL_JUMP,    1'b0, 1'b1, NsFetch,    '0);
      5'd18: uop = mk_uop('0,           1'b0, 1'b0, NsDispatch, '0);
      default: ;
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microcode sequencer: owns the uPC, steps the uop ROM, stalls on memory, halts on illegal.
// MSEQ_PERF_EN adds perf_cycles / perf_retired counters.
module micro_sequencer
  import mseq_pkg::*;
(
  input logic              clk,
  input logic              rst,
  micro_sequencer_if.slave bus
);

  state_e           state_q, state_d;
  logic [UPC_W-1:0] upc_q, upc_d;
  uop_t             uop;
  logic             advance;
  logic             retire;
  logic             br_taken;
  logic             seq_wrap;

  uop_rom u_rom (
    .upc(upc_q),
    .uop(uop)
  );

  assign br_taken = bus.uncond_branch | (bus.cond_branch & bus.br_cond_true);

  always_comb begin
    state_d         = state_q;
    upc_d           = upc_q;
    advance         = 1'b0;
    retire          = 1'b0;
    seq_wrap        = 1'b0;
    bus.id_ready    = 1'b0;
    bus.uop_ctrl    = '0;
    bus.mem_req     = 1'b0;
    bus.take_branch = 1'b0;
    bus.halted      = 1'b0;

    unique case (state_q)
      StFetch: begin
        bus.id_ready = 1'b1;
        if (bus.id_valid_inst) begin
          if (bus.id_illegal) begin
            state_d = StHalt;
          end else if (bus.id_decode_addr == FETCH_ADDR) begin
            // Branch/ebreak entry: resolves and retires without leaving fetch
            retire          = 1'b1;
            bus.take_branch = br_taken;
          end else begin
            upc_d   = bus.id_decode_addr;
            state_d = StExec;
          end
        end
      end
      StExec: begin
        bus.uop_ctrl = uop.ctrl;
        if (uop.br_eval) begin
          bus.take_branch = br_taken;
        end
        if (uop.mem_op) begin
          bus.mem_req = 1'b1;
          advance     = bus.mem_ack;
          if (!bus.mem_ack) begin
            state_d = StMemWait;
          end
        end else begin
          advance = 1'b1;
        end
      end
      StMemWait: begin
        bus.uop_ctrl = uop.ctrl;
        bus.mem_req  = 1'b1;
        advance      = bus.mem_ack;
      end
      StHalt: begin
        bus.halted = 1'b1;
      end
    endcase

    if (advance) begin
      unique case (uop.next_sel)
        NsSeq: begin
          upc_d    = upc_q + UPC_W'(1);
          state_d  = StExec;
          seq_wrap = &upc_q;
        end
        NsJump: begin
          upc_d   = uop.next_addr;
          state_d = StExec;
        end
        NsDispatch: begin
          upc_d   = bus.id_decode_addr;
          state_d = StExec;
        end
        NsFetch: begin
          upc_d   = FETCH_ADDR;
          state_d = StFetch;
          retire  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      upc_q   <= FETCH_ADDR;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
    end
  end

  assign bus.upc          = upc_q;
  assign bus.inst_retired = retire;

  // Microcode must never step sequentially past the top of the ROM
  a_no_seq_wrap: assert property (@(posedge clk) disable iff (rst) !seq_wrap);

`ifdef MSEQ_PERF_EN
  logic [31:0] perf_cycles_q, perf_retired_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles_q  <= '0;
      perf_retired_q <= '0;
    end else begin
      if (state_q != StHalt) begin
        perf_cycles_q <= perf_cycles_q + 32'd1;
      end
      if (retire) begin
        perf_retired_q <= perf_retired_q + 32'd1;
      end
    end
  end

  assign bus.perf_cycles  = perf_cycles_q;
  assign bus.perf_retired = perf_retired_q;
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed self-checking bench for micro_sequencer: reset, ALU, load/store stalls,
// branches, halt and mid-instruction reset; perf counters when MSEQ_PERF_EN is set.
module tb_micro_sequencer;
  import mseq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  micro_sequencer_if bus ();

  micro_sequencer dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

`ifdef MSEQ_PERF_EN
  int unsigned cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end
`endif

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_b(string tag, logic obs, logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_a(string tag, logic [UPC_W-1:0] obs, logic [UPC_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_c(string tag, logic [CTRL_W-1:0] obs, logic [CTRL_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.id_valid_inst  = 1'b0;
    bus.id_illegal     = 1'b0;
    bus.id_decode_addr = 5'd0;
    bus.cond_branch    = 1'b0;
    bus.uncond_branch  = 1'b0;
    bus.br_cond_true   = 1'b0;
    bus.mem_ack        = 1'b0;
  endtask

  task automatic dispatch(logic [UPC_W-1:0] addr);
    bus.id_valid_inst  = 1'b1;
    bus.id_decode_addr = addr;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    #12;
    // Reset state
    chk_a("rst_upc", bus.upc, 5'd18);
    chk_b("rst_id_ready", bus.id_ready, 1'b1);
    chk_b("rst_mem_req", bus.mem_req, 1'b0);
    chk_b("rst_halted", bus.halted, 1'b0);
    chk_c("rst_ctrl", bus.uop_ctrl, 16'h0000);
    chk_b("rst_retired", bus.inst_retired, 1'b0);
    chk_b("rst_take_branch", bus.take_branch, 1'b0);
    rst = 1'b0;

    // Idle fetch: no retire
    #1;
    chk_b("idle_retired", bus.inst_retired, 1'b0);

    // ADD: 18 -> 4 -> 18 with a single retire in the EXEC cycle
    dispatch(5'd4);
    #1;
    chk_b("add_disp_ready", bus.id_ready, 1'b1);
    chk_b("add_disp_retired", bus.inst_retired, 1'b0);
    tick();
    clear_inputs();
    #1;
    chk_a("add_exec_upc", bus.upc, 5'd4);
    chk_c("add_exec_ctrl", bus.uop_ctrl, 16'h0020);
    chk_b("add_exec_ready", bus.id_ready, 1'b0);
    chk_b("add_exec_retired", bus.inst_retired, 1'b1);
    tick();
    chk_a("add_back_upc", bus.upc, 5'd18);
    chk_b("add_back_retired", bus.inst_retired, 1'b0);
    chk_c("add_back_ctrl", bus.uop_ctrl, 16'h0000);

    // LW: ack low for three cycles, high on the fourth
    dispatch(5'd0);
    tick();
    clear_inputs();
    #1;
    chk_b("lw_exec_req", bus.mem_req, 1'b1);
    chk_a("lw_exec_upc", bus.upc, 5'd0);
    chk_c("lw_exec_ctrl", bus.uop_ctrl, 16'h0C10);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_b("lw_wait_req", bus.mem_req, 1'b1);
      chk_a("lw_wait_upc", bus.upc, 5'd0);
      chk_c("lw_wait_ctrl", bus.uop_ctrl, 16'h0C10);
      chk_b("lw_wait_retired", bus.inst_retired, 1'b0);
    end
    tick();
    bus.mem_ack = 1'b1;
    #1;
    chk_b("lw_ack_req", bus.mem_req, 1'b1);
    chk_a("lw_ack_upc", bus.upc, 5'd0);
    chk_b("lw_ack_retired", bus.inst_retired, 1'b0);
    tick();
    bus.mem_ack = 1'b0;
    #1;
    chk_a("lw_wb_upc", bus.upc, 5'd1);
    chk_b("lw_wb_req", bus.mem_req, 1'b0);
    chk_c("lw_wb_ctrl", bus.uop_ctrl, 16'h00A0);
    chk_b("lw_wb_retired", bus.inst_retired, 1'b1);
    tick();
    chk_a("lw_done_upc", bus.upc, 5'd18);

    // SW: store uop acked in its first cycle retires without waiting
    dispatch(5'd2);
    tick();
    clear_inputs();
    #1;
    chk_b("sw_addr_req", bus.mem_req, 1'b0);
    chk_c("sw_addr_ctrl", bus.uop_ctrl, 16'h0410);
    tick();
    bus.mem_ack = 1'b1;
    #1;
    chk_a("sw_mem_upc", bus.upc, 5'd3);
    chk_b("sw_mem_req", bus.mem_req, 1'b1);
    chk_b("sw_mem_retired", bus.inst_retired, 1'b1);
    tick();
    bus.mem_ack = 1'b0;
    #1;
    chk_a("sw_done_upc", bus.upc, 5'd18);
    chk_b("sw_done_req", bus.mem_req, 1'b0);

    // Branches resolved in fetch
    dispatch(5'd18);
    bus.cond_branch  = 1'b1;
    bus.br_cond_true = 1'b1;
    #1;
    chk_b("br_taken", bus.take_branch, 1'b1);
    chk_b("br_taken_retired", bus.inst_retired, 1'b1);
    tick();
    bus.br_cond_true = 1'b0;
    #1;
    chk_b("br_not_taken", bus.take_branch, 1'b0);
    chk_b("br_not_taken_retired", bus.inst_retired, 1'b1);
    chk_a("br_upc", bus.upc, 5'd18);
    tick();
    bus.cond_branch   = 1'b0;
    bus.uncond_branch = 1'b1;
    #1;
    chk_b("br_uncond", bus.take_branch, 1'b1);
    tick();
    clear_inputs();
    #1;
    chk_b("br_idle_take", bus.take_branch, 1'b0);
    chk_b("br_idle_retired", bus.inst_retired, 1'b0);

    // JAL: br_eval uop redirects in its EXEC cycle
    dispatch(5'd14);
    tick();
    clear_inputs();
    bus.uncond_branch = 1'b1;
    #1;
    chk_a("jal_upc", bus.upc, 5'd14);
    chk_b("jal_take", bus.take_branch, 1'b1);
    chk_c("jal_ctrl", bus.uop_ctrl, 16'h0320);
    chk_b("jal_retired", bus.inst_retired, 1'b1);
    tick();
    clear_inputs();
    #1;
    chk_b("jal_after_take", bus.take_branch, 1'b0);

    // Illegal instruction parks the sequencer
    bus.id_valid_inst = 1'b1;
    bus.id_illegal    = 1'b1;
    #1;
    chk_b("ill_disp_halted", bus.halted, 1'b0);
    tick();
    bus.id_illegal     = 1'b0;
    bus.id_decode_addr = 5'd4;
    #1;
    chk_b("ill_halted", bus.halted, 1'b1);
    chk_b("ill_ready", bus.id_ready, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_b("ill_stay_halted", bus.halted, 1'b1);
      chk_a("ill_stay_upc", bus.upc, 5'd18);
      chk_b("ill_stay_req", bus.mem_req, 1'b0);
    end
    rst = 1'b1;
    #1;
    chk_b("ill_rst_halted", bus.halted, 1'b0);
    chk_b("ill_rst_ready", bus.id_ready, 1'b1);
    rst = 1'b0;
    clear_inputs();

    // Reset mid-EXEC
    tick();
    dispatch(5'd0);
    tick();
    clear_inputs();
    #1;
    chk_b("rexec_pre_req", bus.mem_req, 1'b1);
    rst = 1'b1;
    #1;
    chk_a("rexec_upc", bus.upc, 5'd18);
    chk_b("rexec_ready", bus.id_ready, 1'b1);
    chk_b("rexec_req", bus.mem_req, 1'b0);
    chk_b("rexec_halted", bus.halted, 1'b0);
    rst = 1'b0;

    // Reset mid-MEM_WAIT abandons the request without retiring
    tick();
    dispatch(5'd0);
    tick();
    clear_inputs();
    tick();
    chk_b("rwait_pre_req", bus.mem_req, 1'b1);
    rst = 1'b1;
    #1;
    chk_b("rwait_req", bus.mem_req, 1'b0);
    chk_b("rwait_retired", bus.inst_retired, 1'b0);
    chk_a("rwait_upc", bus.upc, 5'd18);
    rst = 1'b0;

`ifdef MSEQ_PERF_EN
    tick();
    rst = 1'b1;
    #1;
    chk_w("perf_rst_cycles", bus.perf_cycles, 32'd0);
    chk_w("perf_rst_retired", bus.perf_retired, 32'd0);
    rst = 1'b0;
    dispatch(5'd4);
    for (int i = 0; i < 6; i++) tick();
    clear_inputs();
    #1;
    chk_w("perf_retired", bus.perf_retired, 32'd3);
    chk_w("perf_cycles_elapsed", bus.perf_cycles, cyc);
    chk_w("perf_cycles", bus.perf_cycles, 32'd6);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
